fpu_unpack_pipe: RTL and testbench
==================================

FPU_UNPACK_PIPE -- requirements
Module: fpu_unpack_pipe

Interface
REQ-001 SHALL have parameter NSRC, default 3, meaning operand lanes per transaction (1..3).
REQ-002 SHALL have parameter CNTW, default 16, meaning width of the bad-NaN-box event counter.
REQ-003 SHALL take FLEN, NE, NF, FPSIZES and the per-format LEN/NE/NF constants from config_pkg.
REQ-004 SHALL have ports:
- clk  in  1  clock.
- reset_n  in  1  reset, asynchronous, active-low.
- flush  in  1  discards all held transactions.
- in_valid  in  1  transaction offered.
- in_ready  out  1  transaction accepted when high with in_valid.
- in_fmt  in  FMTBITS  format: 00 single, 01 double, 10 half, 11 quad.
- in_en  in  NSRC  per-lane operand enable.
- in_op  in  NSRC*FLEN  packed raw register-file operands.
- out_valid  out  1  result available.
- out_ready  in  1  consumer takes result.
- out_sgn  out  NSRC  sign per lane.
- out_exp  out  NSRC*NE  exponent rebiased to the largest format.
- out_man  out  NSRC*(NF+1)  significand with the implicit bit.
- out_flags  out  NSRC*6  {NaN,SNaN,Zero,Inf,ExpMax,Subnorm} per lane.
- out_postbox  out  NSRC*FLEN  operand after NaN-box correction.
- out_class  out  NSRC*10  RISC-V fclass mask per lane.
- badbox_cnt  out  CNTW  saturating count of improperly boxed operands.
- cnt_clr  in  1  synchronous clear of badbox_cnt.

Function
REQ-005 SHALL unpack each lane combinationally at input: narrow format needs all bits above its length set, else the lane SHALL be treated as a positive canonical quiet NaN with NaN=1, SNaN=0, and postbox = upper ones followed by the narrow format's canonical qNaN.
REQ-006 SHALL rebias narrow exponents as {msb, (NE-NEx) copies of ~msb, remaining bits}; a zero or subnormal input SHALL report effective biased exponent 1.
REQ-007 SHALL left-align the fraction into NF bits; out_man = {exponent-nonzero, fraction}.
REQ-008 SHALL gate a lane whose in_en is 0 so that all its outputs are 0, the NaN flag included.
REQ-009 SHALL treat formats absent from FPSIZES as illegal; flags then X in simulation, with no state corruption.
REQ-010 SHALL register results with latency 1: a transaction accepted at edge N is presented with out_valid=1 after edge N.
REQ-011 SHALL implement a two-entry elastic buffer (main plus skid) so that in_ready is a register output and back-to-back throughput is 1 per cycle while out_ready=1.
REQ-012 SHALL hold out_* stable while out_valid=1 and out_ready=0.
REQ-013 SHALL deassert in_ready only when both entries are full; a simultaneous accept and drain with one entry held SHALL keep occupancy at 1.
REQ-014 SHALL deliver results in acceptance order, with no loss or duplication.
REQ-015 SHALL, on flush, empty both entries next edge, drive out_valid=0 and in_ready=1, and ignore any in_valid presented in the flush cycle.
REQ-016 SHALL increment badbox_cnt by the number of bad-boxed enabled lanes per accepted transaction, saturating at all-ones; cnt_clr SHALL take priority over increment; flushed transactions still count.

Reset
REQ-017 SHALL, on reset_n low, immediately force out_valid=0, in_ready=0, badbox_cnt=0 and both entries empty, with data registers 0.
REQ-018 SHALL raise in_ready on the first clk edge after reset_n deasserts; a reset asserted mid-operation SHALL drop held transactions.

Configuration
REQ-019 SHALL define macro FPU_UNPACK_CLASS_EN: when defined, out_class is the registered 10-bit fclass mask per lane (bits 0..9: -inf, -norm, -sub, -0, +0, +sub, +norm, +inf, sNaN, qNaN); when undefined, out_class SHALL be constant 0 and no class logic is synthesised.

Structure
REQ-020 SHALL place the format encodings (FMT_S/D/H/Q), the flag bit indices and the typedef unpacked_lane_t {sgn, exp, man, flags, postbox, class} in config_pkg.
REQ-021 SHALL instantiate sub-module fpu_unpack_lane (combinational, one per lane) via generate; the buffering and the counter SHALL reside in fpu_unpack_pipe.

Verification
REQ-022 SHALL cover: FLEN=64, lane0=0xFFFFFFFF_3F800000, fmt=00 -> sgn 0, exp 0x3FF, man 0x10000000000000, flags 0, class bit 6 set.
REQ-023 SHALL cover: lane0=0x00000000_BF800000, fmt=00 -> NaN=1, SNaN=0, sgn 0, postbox 0xFFFFFFFF_7FC00000, badbox_cnt +1, class bit 9.
REQ-024 SHALL cover: fmt=01 with lanes 0x0000000000000001, 0x7FF0000000000001 and 0xFFF0000000000000 -> lane0 Subnorm exp 1 man 1; lane1 SNaN; lane2 Inf sgn 1 class bit 0.
REQ-025 SHALL cover: out_ready=0 for 3 cycles while 3 transactions are offered -> in_ready falls after 2 accepts, outputs are stable, then drain in order in 2 cycles.
REQ-026 SHALL cover: flush with both entries full and in_valid=1 -> next cycle out_valid=0, in_ready=1, with no output of the flushed or offered data.
REQ-027 SHALL cover: CNTW=4 and 20 bad-boxed lanes -> badbox_cnt saturates at 0xF; cnt_clr with a simultaneous bad box -> 0.

Source files
------------

// File: rtl/config_pkg.sv
// -----------------------------------------------------------------------------
// config_pkg
// Shared configuration for the FPU operand unpacker.
//   - FLEN / NE / NF    : widths of the largest supported format
//   - FPSIZES           : one bit per format code, set when that format exists
//   - LEN_x/NE_x/NF_x   : per-format total, exponent and fraction widths
//   - FMT_S/D/H/Q       : format encodings carried on in_fmt
//   - FLAG_*            : bit positions inside the 6-bit per-lane flag vector
//   - unpacked_lane_t   : everything one lane produces, as stored in the pipe
//   - classify()        : RISC-V fclass mask from sign and flags
// -----------------------------------------------------------------------------
package config_pkg;

    localparam int FLEN    = 64;
    localparam int NE      = 11;
    localparam int NF      = 52;
    localparam int FMTBITS = 2;

    localparam int LEN_S = 32;
    localparam int NE_S  = 8;
    localparam int NF_S  = 23;
    localparam int LEN_D = 64;
    localparam int NE_D  = 11;
    localparam int NF_D  = 52;
    localparam int LEN_H = 16;
    localparam int NE_H  = 5;
    localparam int NF_H  = 10;
    localparam int LEN_Q = 128;
    localparam int NE_Q  = 15;
    localparam int NF_Q  = 112;

    typedef enum logic [FMTBITS-1:0] {
        FMT_S = 2'b00,
        FMT_D = 2'b01,
        FMT_H = 2'b10,
        FMT_Q = 2'b11
    } fp_fmt_e;

    // Indexed by format code: quad does not fit in a 64-bit register file.
    localparam logic [3:0] FPSIZES = 4'b0111;

    // Canonical quiet NaNs substituted for badly boxed narrow operands.
    localparam logic [LEN_S-1:0] QNAN_S = 32'h7FC0_0000;
    localparam logic [LEN_H-1:0] QNAN_H = 16'h7E00;

    localparam int NFLAGS       = 6;
    localparam int FLAG_NAN     = 5;
    localparam int FLAG_SNAN    = 4;
    localparam int FLAG_ZERO    = 3;
    localparam int FLAG_INF     = 2;
    localparam int FLAG_EXPMAX  = 1;
    localparam int FLAG_SUBNORM = 0;

    localparam int NCLASS = 10;

    typedef struct packed {
        logic              sgn;
        logic [NE-1:0]     exp;
        logic [NF:0]       man;
        logic [NFLAGS-1:0] flags;
        logic [FLEN-1:0]   postbox;
        logic [NCLASS-1:0] fclass;
    } unpacked_lane_t;

    // Bits 0..9: -inf, -norm, -sub, -0, +0, +sub, +norm, +inf, sNaN, qNaN.
    function automatic logic [NCLASS-1:0] classify(input logic sgn, input logic [NFLAGS-1:0] flags);
        logic isNorm;
        logic [NCLASS-1:0] mask;
        isNorm  = ~flags[FLAG_EXPMAX] & ~flags[FLAG_ZERO] & ~flags[FLAG_SUBNORM];
        mask[0] =  sgn & flags[FLAG_INF];
        mask[1] =  sgn & isNorm;
        mask[2] =  sgn & flags[FLAG_SUBNORM];
        mask[3] =  sgn & flags[FLAG_ZERO];
        mask[4] = ~sgn & flags[FLAG_ZERO];
        mask[5] = ~sgn & flags[FLAG_SUBNORM];
        mask[6] = ~sgn & isNorm;
        mask[7] = ~sgn & flags[FLAG_INF];
        mask[8] =  flags[FLAG_SNAN];
        mask[9] =  flags[FLAG_NAN] & ~flags[FLAG_SNAN];
        return mask;
    endfunction

endpackage

// File: rtl/fpu_unpack_lane.sv
// -----------------------------------------------------------------------------
// fpu_unpack_lane
// Purely combinational unpacker for one register-file operand.
//   op_i      : raw FLEN-bit operand
//   fmt_i     : format code (FMT_S/D/H/Q)
//   en_i      : lane enable; when low every output is zero
//   lane_o    : sign, rebiased exponent, significand, flags, post-box value,
//               fclass mask
//   badbox_o  : the enabled, legal-format operand was not properly NaN-boxed
// Macro FPU_UNPACK_CLASS_EN: when defined the fclass mask is computed,
// otherwise lane_o.fclass is tied to zero.
// -----------------------------------------------------------------------------
module fpu_unpack_lane
    import config_pkg::*;
(
    input  logic [FLEN-1:0]    op_i,
    input  logic [FMTBITS-1:0] fmt_i,
    input  logic               en_i,
    output unpacked_lane_t     lane_o,
    output logic               badbox_o
);

    logic [LEN_S-1:0] valS;
    logic [LEN_H-1:0] valH;
    logic [NE_S-1:0]  expS;
    logic [NE_H-1:0]  expH;
    logic             sgn;
    logic             expNz;
    logic             expMax;
    logic             fracNz;
    logic             quietBit;
    logic             legal;
    logic             boxOk;
    logic [NE-1:0]    expReb;
    logic [NF-1:0]    fracAl;
    logic [FLEN-1:0]  postbox;

    // Field extraction per format. A narrow operand whose upper bits are not
    // all ones is replaced by that format's canonical qNaN before decoding,
    // so the rest of the datapath never sees the bad value. Zero/subnormal
    // exponents are decoded as biased 1 before rebiasing.
    always_comb begin
        valS     = '0;
        valH     = '0;
        expS     = '0;
        expH     = '0;
        sgn      = 1'b0;
        expNz    = 1'b0;
        expMax   = 1'b0;
        fracNz   = 1'b0;
        quietBit = 1'b0;
        legal    = FPSIZES[fmt_i];
        boxOk    = 1'b1;
        expReb   = '0;
        fracAl   = '0;
        postbox  = '0;
        case (fmt_i)
            FMT_S: begin
                boxOk    = &op_i[FLEN-1:LEN_S];
                valS     = boxOk ? op_i[LEN_S-1:0] : QNAN_S;
                sgn      = valS[LEN_S-1];
                expNz    = |valS[LEN_S-2 -: NE_S];
                expMax   = &valS[LEN_S-2 -: NE_S];
                fracNz   = |valS[NF_S-1:0];
                quietBit = valS[NF_S-1];
                expS     = expNz ? valS[LEN_S-2 -: NE_S] : NE_S'(1);
                expReb   = {expS[NE_S-1], {(NE-NE_S){~expS[NE_S-1]}}, expS[NE_S-2:0]};
                fracAl   = {valS[NF_S-1:0], {(NF-NF_S){1'b0}}};
                postbox  = {{(FLEN-LEN_S){1'b1}}, valS};
            end
            FMT_H: begin
                boxOk    = &op_i[FLEN-1:LEN_H];
                valH     = boxOk ? op_i[LEN_H-1:0] : QNAN_H;
                sgn      = valH[LEN_H-1];
                expNz    = |valH[LEN_H-2 -: NE_H];
                expMax   = &valH[LEN_H-2 -: NE_H];
                fracNz   = |valH[NF_H-1:0];
                quietBit = valH[NF_H-1];
                expH     = expNz ? valH[LEN_H-2 -: NE_H] : NE_H'(1);
                expReb   = {expH[NE_H-1], {(NE-NE_H){~expH[NE_H-1]}}, expH[NE_H-2:0]};
                fracAl   = {valH[NF_H-1:0], {(NF-NF_H){1'b0}}};
                postbox  = {{(FLEN-LEN_H){1'b1}}, valH};
            end
            FMT_D: begin
                sgn      = op_i[LEN_D-1];
                expNz    = |op_i[LEN_D-2 -: NE_D];
                expMax   = &op_i[LEN_D-2 -: NE_D];
                fracNz   = |op_i[NF_D-1:0];
                quietBit = op_i[NF_D-1];
                expReb   = expNz ? op_i[LEN_D-2 -: NE_D] : NE'(1);
                fracAl   = op_i[NF_D-1:0];
                postbox  = op_i;
            end
            default: ;
        endcase
    end

    // Flag derivation and lane gating. Illegal formats leave the flags
    // undefined but never report a bad box, so the counter stays clean.
    always_comb begin
        lane_o   = '0;
        badbox_o = 1'b0;
        if (en_i) begin
            lane_o.sgn                  = sgn;
            lane_o.exp                  = expReb;
            lane_o.man                  = {expNz, fracAl};
            lane_o.postbox              = postbox;
            lane_o.flags[FLAG_NAN]      = expMax & fracNz;
            lane_o.flags[FLAG_SNAN]     = expMax & fracNz & ~quietBit;
            lane_o.flags[FLAG_ZERO]     = ~expNz & ~fracNz;
            lane_o.flags[FLAG_INF]      = expMax & ~fracNz;
            lane_o.flags[FLAG_EXPMAX]   = expMax;
            lane_o.flags[FLAG_SUBNORM]  = ~expNz & fracNz;
            badbox_o                    = legal & ~boxOk;
            if (!legal) begin
                lane_o.flags = 'x;
            end
`ifdef FPU_UNPACK_CLASS_EN
            lane_o.fclass = classify(sgn, lane_o.flags);
`endif
        end
    end

endmodule

// File: rtl/fpu_unpack_pipe.sv
// -----------------------------------------------------------------------------
// fpu_unpack_pipe
// NSRC-lane FPU operand unpacker with a one-cycle registered output and a
// two-entry (main + skid) elastic buffer, plus a saturating counter of
// improperly NaN-boxed operands.
//   clk, reset_n           : clock, asynchronous active-low reset
//   flush                  : drop everything held, ignore this cycle's input
//   in_valid/in_ready      : input handshake; in_ready is a flop output
//   in_fmt, in_en, in_op   : format, per-lane enable, packed raw operands
//   out_valid/out_ready    : output handshake
//   out_sgn/exp/man/flags  : unpacked fields per lane
//   out_postbox            : operand after NaN-box correction per lane
//   out_class              : fclass mask per lane (zero unless enabled)
//   badbox_cnt, cnt_clr    : bad-box event counter and its synchronous clear
// Macro FPU_UNPACK_CLASS_EN enables the fclass mask inside fpu_unpack_lane;
// without it the lanes drive zero and out_class stays constant 0.
// -----------------------------------------------------------------------------
module fpu_unpack_pipe
    import config_pkg::*;
#(
    parameter int NSRC = 3,
    parameter int CNTW = 16
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     flush,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [FMTBITS-1:0]       in_fmt,
    input  logic [NSRC-1:0]          in_en,
    input  logic [NSRC*FLEN-1:0]     in_op,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [NSRC-1:0]          out_sgn,
    output logic [NSRC*NE-1:0]       out_exp,
    output logic [NSRC*(NF+1)-1:0]   out_man,
    output logic [NSRC*NFLAGS-1:0]   out_flags,
    output logic [NSRC*FLEN-1:0]     out_postbox,
    output logic [NSRC*NCLASS-1:0]   out_class,
    output logic [CNTW-1:0]          badbox_cnt,
    input  logic                     cnt_clr
);

    localparam int SUMW = $clog2(NSRC + 1);

    unpacked_lane_t [NSRC-1:0] laneIn;
    logic [NSRC-1:0]           laneBad;

    unpacked_lane_t [NSRC-1:0] mainData_q, mainData_d;
    unpacked_lane_t [NSRC-1:0] skidData_q, skidData_d;
    logic                      mainValid_q, mainValid_d;
    logic                      skidValid_q, skidValid_d;
    logic                      inReady_q, inReady_d;
    logic [CNTW-1:0]           cnt_q, cnt_d;

    logic                      accept;
    logic                      drain;
    logic [SUMW-1:0]           badSum;
    logic [CNTW:0]             cntSum;

    for (genvar g = 0; g < NSRC; g++) begin : gLane
        fpu_unpack_lane uLane (
            .op_i     (in_op[g*FLEN +: FLEN]),
            .fmt_i    (in_fmt),
            .en_i     (in_en[g]),
            .lane_o   (laneIn[g]),
            .badbox_o (laneBad[g])
        );
    end

    assign accept = in_valid & inReady_q & ~flush;
    assign drain  = mainValid_q & out_ready;

    // Elastic buffer next state. The skid entry only fills while main is
    // stalled; when main drains the skid moves forward. While skid is full
    // in_ready is already low, so no accept can coincide with that move.
    always_comb begin
        mainValid_d = mainValid_q;
        skidValid_d = skidValid_q;
        mainData_d  = mainData_q;
        skidData_d  = skidData_q;
        if (flush) begin
            mainValid_d = 1'b0;
            skidValid_d = 1'b0;
        end else if (drain) begin
            if (skidValid_q) begin
                mainData_d  = skidData_q;
                skidValid_d = 1'b0;
            end else begin
                mainValid_d = accept;
                if (accept) begin
                    mainData_d = laneIn;
                end
            end
        end else if (accept) begin
            if (!mainValid_q) begin
                mainValid_d = 1'b1;
                mainData_d  = laneIn;
            end else begin
                skidValid_d = 1'b1;
                skidData_d  = laneIn;
            end
        end
        inReady_d = ~(mainValid_d & skidValid_d);
    end

    // Saturating bad-box counter; clear wins over any same-cycle increment.
    always_comb begin
        badSum = '0;
        for (int i = 0; i < NSRC; i++) begin
            badSum = badSum + SUMW'(laneBad[i]);
        end
        cntSum = {1'b0, cnt_q} + (CNTW+1)'(badSum);
        cnt_d  = cnt_q;
        if (cnt_clr) begin
            cnt_d = '0;
        end else if (accept) begin
            cnt_d = cntSum[CNTW] ? '1 : cntSum[CNTW-1:0];
        end
    end

    // State registers; reset empties the buffer and holds in_ready low.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mainValid_q <= 1'b0;
            skidValid_q <= 1'b0;
            inReady_q   <= 1'b0;
            mainData_q  <= '0;
            skidData_q  <= '0;
            cnt_q       <= '0;
        end else begin
            mainValid_q <= mainValid_d;
            skidValid_q <= skidValid_d;
            inReady_q   <= inReady_d;
            mainData_q  <= mainData_d;
            skidData_q  <= skidData_d;
            cnt_q       <= cnt_d;
        end
    end

    assign in_ready   = inReady_q;
    assign out_valid  = mainValid_q;
    assign badbox_cnt = cnt_q;

    for (genvar g = 0; g < NSRC; g++) begin : gOut
        assign out_sgn[g]                      = mainData_q[g].sgn;
        assign out_exp[g*NE +: NE]             = mainData_q[g].exp;
        assign out_man[g*(NF+1) +: (NF+1)]     = mainData_q[g].man;
        assign out_flags[g*NFLAGS +: NFLAGS]   = mainData_q[g].flags;
        assign out_postbox[g*FLEN +: FLEN]     = mainData_q[g].postbox;
        assign out_class[g*NCLASS +: NCLASS]   = mainData_q[g].fclass;
    end

endmodule

// File: tb/tb_fpu_unpack_pipe.sv
// -----------------------------------------------------------------------------
// tb_fpu_unpack_pipe
// Directed bench for fpu_unpack_pipe (NSRC=3, CNTW=4). Inputs change and
// outputs are sampled on the falling clock edge; the design acts on the
// rising edge. Expected values are written out by hand per step.
// -----------------------------------------------------------------------------
module tb_fpu_unpack_pipe;
    import config_pkg::*;

    localparam int NSRC = 3;
    localparam int CNTW = 4;

`ifdef FPU_UNPACK_CLASS_EN
    localparam bit ClassOn = 1'b1;
`else
    localparam bit ClassOn = 1'b0;
`endif

    logic                    clk = 1'b0;
    logic                    reset_n;
    logic                    flush;
    logic                    in_valid;
    logic                    in_ready;
    logic [FMTBITS-1:0]      in_fmt;
    logic [NSRC-1:0]         in_en;
    logic [NSRC*FLEN-1:0]    in_op;
    logic                    out_valid;
    logic                    out_ready;
    logic [NSRC-1:0]         out_sgn;
    logic [NSRC*NE-1:0]      out_exp;
    logic [NSRC*(NF+1)-1:0]  out_man;
    logic [NSRC*NFLAGS-1:0]  out_flags;
    logic [NSRC*FLEN-1:0]    out_postbox;
    logic [NSRC*NCLASS-1:0]  out_class;
    logic [CNTW-1:0]         badbox_cnt;
    logic                    cnt_clr;

    int testCount = 0;
    int failCount = 0;
    int expCnt;

    always #5 clk = ~clk;

    fpu_unpack_pipe #(.NSRC(NSRC), .CNTW(CNTW)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .flush       (flush),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_fmt      (in_fmt),
        .in_en       (in_en),
        .in_op       (in_op),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_sgn     (out_sgn),
        .out_exp     (out_exp),
        .out_man     (out_man),
        .out_flags   (out_flags),
        .out_postbox (out_postbox),
        .out_class   (out_class),
        .badbox_cnt  (badbox_cnt),
        .cnt_clr     (cnt_clr)
    );

    function automatic logic [NE-1:0] expOf(input int i);
        return out_exp[i*NE +: NE];
    endfunction

    function automatic logic [NF:0] manOf(input int i);
        return out_man[i*(NF+1) +: (NF+1)];
    endfunction

    function automatic logic [NFLAGS-1:0] flagsOf(input int i);
        return out_flags[i*NFLAGS +: NFLAGS];
    endfunction

    function automatic logic [FLEN-1:0] postOf(input int i);
        return out_postbox[i*FLEN +: FLEN];
    endfunction

    function automatic logic [NCLASS-1:0] classOf(input int i);
        return out_class[i*NCLASS +: NCLASS];
    endfunction

    function automatic logic [NCLASS-1:0] classExp(input logic [NCLASS-1:0] mask);
        return ClassOn ? mask : '0;
    endfunction

    // One comparison: counts it, and on mismatch counts and reports it.
    task automatic checkOutput(input string tag, input logic [127:0] observed, input logic [127:0] expected);
        testCount++;
        assert (observed === expected) else begin
            failCount++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Offers one transaction; the caller decides how long it stays offered.
    task automatic applyStimulus(input logic [1:0] fmt, input logic [2:0] en,
                                 input logic [63:0] op0, input logic [63:0] op1, input logic [63:0] op2);
        in_fmt   = fmt;
        in_en    = en;
        in_op    = {op2, op1, op0};
        in_valid = 1'b1;
    endtask

    initial begin
        reset_n   = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_fmt    = '0;
        in_en     = '0;
        in_op     = '0;
        out_ready = 1'b1;
        cnt_clr   = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        checkOutput("rst_out_valid", out_valid, 0);
        checkOutput("rst_in_ready", in_ready, 0);
        checkOutput("rst_badbox", badbox_cnt, 0);
        checkOutput("rst_postbox", out_postbox, 0);
        reset_n = 1'b1;
        @(negedge clk);
        checkOutput("post_rst_in_ready", in_ready, 1);
        checkOutput("post_rst_out_valid", out_valid, 0);

        // Single 1.0, properly boxed
        applyStimulus(FMT_S, 3'b001, 64'hFFFF_FFFF_3F80_0000, 64'h0, 64'h0);
        @(negedge clk);
        in_valid = 1'b0;
        checkOutput("s1_valid", out_valid, 1);
        checkOutput("s1_sgn", out_sgn[0], 0);
        checkOutput("s1_exp", expOf(0), 11'h3FF);
        checkOutput("s1_man", manOf(0), 53'h10_0000_0000_0000);
        checkOutput("s1_flags", flagsOf(0), 6'h00);
        checkOutput("s1_class", classOf(0), classExp(10'h040));
        checkOutput("s1_post", postOf(0), 64'hFFFF_FFFF_3F80_0000);
        checkOutput("s1_lane12_flags", out_flags[17:6], 0);
        checkOutput("s1_lane1_post", postOf(1), 0);
        checkOutput("s1_badbox", badbox_cnt, 0);

        // Badly boxed single becomes canonical qNaN; disabled lane 1 is also bad but ignored
        applyStimulus(FMT_S, 3'b001, 64'h0000_0000_BF80_0000, 64'h0, 64'h0);
        @(negedge clk);
        in_valid = 1'b0;
        checkOutput("bb_nan", out_flags[FLAG_NAN], 1);
        checkOutput("bb_snan", out_flags[FLAG_SNAN], 0);
        checkOutput("bb_sgn", out_sgn[0], 0);
        checkOutput("bb_post", postOf(0), 64'hFFFF_FFFF_7FC0_0000);
        checkOutput("bb_cnt", badbox_cnt, 1);
        checkOutput("bb_class", classOf(0), classExp(10'h200));
        checkOutput("bb_lane1_flags", flagsOf(1), 0);

        // Doubles: subnormal, signalling NaN, negative infinity
        applyStimulus(FMT_D, 3'b111, 64'h0000_0000_0000_0001, 64'h7FF0_0000_0000_0001, 64'hFFF0_0000_0000_0000);
        @(negedge clk);
        in_valid = 1'b0;
        checkOutput("d_l0_exp", expOf(0), 11'h001);
        checkOutput("d_l0_man", manOf(0), 53'h1);
        checkOutput("d_l0_flags", flagsOf(0), 6'h01);
        checkOutput("d_l0_class", classOf(0), classExp(10'h020));
        checkOutput("d_l1_flags", flagsOf(1), 6'h32);
        checkOutput("d_l1_class", classOf(1), classExp(10'h100));
        checkOutput("d_l2_flags", flagsOf(2), 6'h06);
        checkOutput("d_l2_sgn", out_sgn[2], 1);
        checkOutput("d_l2_exp", expOf(2), 11'h7FF);
        checkOutput("d_l2_class", classOf(2), classExp(10'h001));
        checkOutput("d_cnt", badbox_cnt, 1);

        // Halves: 1.0 and smallest subnormal exercise exponent rebiasing
        applyStimulus(FMT_H, 3'b011, 64'hFFFF_FFFF_FFFF_3C00, 64'hFFFF_FFFF_FFFF_0001, 64'h0);
        @(negedge clk);
        in_valid = 1'b0;
        checkOutput("h_l0_exp", expOf(0), 11'h3FF);
        checkOutput("h_l0_man", manOf(0), 53'h10_0000_0000_0000);
        checkOutput("h_l1_exp", expOf(1), 11'h3F1);
        checkOutput("h_l1_man", manOf(1), 53'h400_0000_0000);
        checkOutput("h_l1_flags", flagsOf(1), 6'h01);
        checkOutput("h_cnt", badbox_cnt, 1);

        // Quad is illegal here: must not disturb the counter
        applyStimulus(FMT_Q, 3'b001, 64'h0, 64'h0, 64'h0);
        @(negedge clk);
        in_valid = 1'b0;
        checkOutput("q_valid", out_valid, 1);
        checkOutput("q_cnt", badbox_cnt, 1);
        @(negedge clk);
        checkOutput("q_drained", out_valid, 0);

        // Backpressure: three offers while out_ready is low for three cycles
        out_ready = 1'b0;
        applyStimulus(FMT_D, 3'b001, 64'h4000_0000_0000_0000, 64'h0, 64'h0);
        @(negedge clk);
        checkOutput("bp1_valid", out_valid, 1);
        checkOutput("bp1_ready", in_ready, 1);
        checkOutput("bp1_post", postOf(0), 64'h4000_0000_0000_0000);
        applyStimulus(FMT_D, 3'b001, 64'h4000_0000_0000_0001, 64'h0, 64'h0);
        @(negedge clk);
        checkOutput("bp2_ready", in_ready, 0);
        checkOutput("bp2_post", postOf(0), 64'h4000_0000_0000_0000);
        applyStimulus(FMT_D, 3'b001, 64'h4000_0000_0000_0002, 64'h0, 64'h0);
        @(negedge clk);
        checkOutput("bp3_ready", in_ready, 0);
        checkOutput("bp3_valid", out_valid, 1);
        checkOutput("bp3_post", postOf(0), 64'h4000_0000_0000_0000);
        out_ready = 1'b1;
        @(negedge clk);
        checkOutput("bp4_post", postOf(0), 64'h4000_0000_0000_0001);
        checkOutput("bp4_ready", in_ready, 1);
        @(negedge clk);
        in_valid = 1'b0;
        checkOutput("bp5_valid", out_valid, 1);
        checkOutput("bp5_post", postOf(0), 64'h4000_0000_0000_0002);
        @(negedge clk);
        checkOutput("bp6_valid", out_valid, 0);

        // Flush with both entries full and a transaction offered
        out_ready = 1'b0;
        applyStimulus(FMT_D, 3'b001, 64'h4010_0000_0000_0000, 64'h0, 64'h0);
        @(negedge clk);
        applyStimulus(FMT_D, 3'b001, 64'h4020_0000_0000_0000, 64'h0, 64'h0);
        @(negedge clk);
        checkOutput("fl_full_ready", in_ready, 0);
        checkOutput("fl_full_post", postOf(0), 64'h4010_0000_0000_0000);
        flush = 1'b1;
        applyStimulus(FMT_S, 3'b001, 64'h0, 64'h0, 64'h0);
        @(negedge clk);
        flush    = 1'b0;
        in_valid = 1'b0;
        checkOutput("fl_valid", out_valid, 0);
        checkOutput("fl_ready", in_ready, 1);
        checkOutput("fl_cnt", badbox_cnt, 1);
        out_ready = 1'b1;
        @(negedge clk);
        checkOutput("fl_no_leak", out_valid, 0);

        // Flush while in_ready is high: the offered transaction must be ignored
        out_ready = 1'b0;
        applyStimulus(FMT_D, 3'b001, 64'h4030_0000_0000_0000, 64'h0, 64'h0);
        @(negedge clk);
        checkOutput("fl2_ready_before", in_ready, 1);
        flush = 1'b1;
        applyStimulus(FMT_S, 3'b001, 64'h0, 64'h0, 64'h0);
        @(negedge clk);
        flush    = 1'b0;
        in_valid = 1'b0;
        checkOutput("fl2_valid", out_valid, 0);
        checkOutput("fl2_cnt", badbox_cnt, 1);
        out_ready = 1'b1;
        @(negedge clk);
        checkOutput("fl2_no_leak", out_valid, 0);

        // Counter clear, then saturation with 20 bad lanes back to back
        cnt_clr = 1'b1;
        @(negedge clk);
        cnt_clr = 1'b0;
        checkOutput("clr_cnt", badbox_cnt, 0);
        expCnt = 0;
        for (int k = 0; k < 7; k++) begin
            applyStimulus(FMT_S, (k == 6) ? 3'b011 : 3'b111, 64'h0, 64'h0, 64'h0);
            @(negedge clk);
            expCnt = expCnt + ((k == 6) ? 2 : 3);
            if (expCnt > 15) expCnt = 15;
            checkOutput($sformatf("sat_cnt_%0d", k), badbox_cnt, expCnt);
            checkOutput($sformatf("sat_ready_%0d", k), in_ready, 1);
        end
        applyStimulus(FMT_S, 3'b111, 64'h0, 64'h0, 64'h0);
        cnt_clr = 1'b1;
        @(negedge clk);
        cnt_clr  = 1'b0;
        in_valid = 1'b0;
        checkOutput("clr_prio_cnt", badbox_cnt, 0);
        checkOutput("clr_prio_nan", out_flags[FLAG_NAN], 1);
        applyStimulus(FMT_S, 3'b001, 64'h0, 64'h0, 64'h0);
        @(negedge clk);
        in_valid = 1'b0;
        checkOutput("after_clr_cnt", badbox_cnt, 1);

        // Reset in the middle of operation drops the held transaction
        out_ready = 1'b0;
        applyStimulus(FMT_D, 3'b001, 64'h4040_0000_0000_0000, 64'h0, 64'h0);
        @(negedge clk);
        in_valid = 1'b0;
        checkOutput("mid_valid", out_valid, 1);
        #2 reset_n = 1'b0;
        #1;
        checkOutput("mid_rst_valid", out_valid, 0);
        checkOutput("mid_rst_ready", in_ready, 0);
        checkOutput("mid_rst_cnt", badbox_cnt, 0);
        @(negedge clk);
        reset_n   = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        checkOutput("mid_rel_ready", in_ready, 1);
        checkOutput("mid_rel_valid", out_valid, 0);

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule
